// File: rtl/link_ctrl.sv
// link_ctrl: half-duplex TX/RX sequencer between inFIFO/msk_modulator and cdr/outFIFO.
// Optional LINK_AUTO_RX_EN: after a TX frame, TURN falls straight into an acknowledgement RX frame.
module link_ctrl #(
  parameter int unsigned FRAME_BITS        = 32,
  parameter int unsigned TIMEOUT_CYCLES    = 1024,
  parameter int unsigned TURNAROUND_CYCLES = 8
) (
  input  logic       inClock,
  input  logic       inReset,
  input  logic       inTxRequest,
  input  logic       inRxEnable,
  input  logic       inFifoEmpty,
  input  logic       inCoderReady,
  input  logic       inCdrFlag,
  input  logic       inCdrData,
  input  logic       inOutFifoFull,
  output logic       outFifoReadEnable,
  output logic       outCoderEmpty,
  output logic       outOutFifoWriteEnable,
  output logic       outOutFifoData,
  output logic       outBusy,
  output logic       outTxDone,
  output logic       outRxDone,
  output logic       outTimeout,
  output logic       outOverflow,
  output logic [1:0] outState,
  output logic [7:0] outBitCount
);
  // state | meaning
  // IDLE  | waiting for a TX request or RX enable
  // TX    | streaming inFIFO bits to the coder
  // TURN  | guard turnaround, all inputs ignored
  // RX    | writing recovered cdr bits into outFIFO
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TX   = 2'd1,
    ST_TURN = 2'd2,
    ST_RX   = 2'd3
  } state_t;

`ifdef LINK_AUTO_RX_EN
  localparam bit AUTO_RX = 1'b1;
`else
  localparam bit AUTO_RX = 1'b0;
`endif

  localparam logic [7:0]  LAST_BIT  = 8'(FRAME_BITS - 1);
  localparam logic [15:0] IDLE_LOAD = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  TURN_LOAD = 8'(TURNAROUND_CYCLES - 1);

  state_t      state, state_next;
  logic [15:0] idle_left;
  logic [7:0]  turn_left;
  logic        auto_pending, auto_rx;
  logic        idle_tc, enter_frame;
  logic        tx_last, rx_accept, rx_drop, rx_last, timeout_hit;

  assign outFifoReadEnable = (state == ST_TX) & inCoderReady & ~inFifoEmpty;
  assign outCoderEmpty     = (state != ST_TX) | inFifoEmpty;
  assign outBusy           = (state != ST_IDLE);
  assign outState          = state;
  assign idle_tc           = (idle_left == 16'd0);
  assign enter_frame       = (state_next != state) && ((state_next == ST_TX) || (state_next == ST_RX));

  always_comb begin
    state_next  = state;
    tx_last     = 1'b0;
    rx_accept   = 1'b0;
    rx_drop     = 1'b0;
    rx_last     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (inTxRequest)     state_next = ST_TX;
        else if (inRxEnable) state_next = ST_RX;
      end
      ST_TX: begin
        // a transfer in the same cycle always beats the timeout
        if (outFifoReadEnable) begin
          if (outBitCount == LAST_BIT) begin
            tx_last    = 1'b1;
            state_next = ST_TURN;
          end
        end else if (idle_tc) begin
          timeout_hit = 1'b1;
          state_next  = ST_TURN;
        end
      end
      ST_RX: begin
        if (!inRxEnable && !auto_rx) begin
          state_next = ST_TURN;
        end else if (inCdrFlag) begin
          if (inOutFifoFull) begin
            rx_drop = 1'b1;
          end else begin
            rx_accept = 1'b1;
            if (outBitCount == LAST_BIT) begin
              rx_last    = 1'b1;
              state_next = ST_TURN;
            end
          end
        end else if (idle_tc) begin
          timeout_hit = 1'b1;
          state_next  = ST_TURN;
        end
      end
      ST_TURN: begin
        if (turn_left == 8'd0) state_next = auto_pending ? ST_RX : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge inClock) begin
    if (!inReset) begin
      state                 <= ST_IDLE;
      outBitCount           <= '0;
      idle_left             <= '0;
      turn_left             <= '0;
      auto_pending          <= 1'b0;
      auto_rx               <= 1'b0;
      outTxDone             <= 1'b0;
      outRxDone             <= 1'b0;
      outTimeout            <= 1'b0;
      outOverflow           <= 1'b0;
      outOutFifoWriteEnable <= 1'b0;
      outOutFifoData        <= 1'b0;
    end else begin
      state                 <= state_next;
      outTxDone             <= tx_last;
      outRxDone             <= rx_last;
      outTimeout            <= timeout_hit;
      outOutFifoWriteEnable <= rx_accept;
      if (rx_accept) outOutFifoData <= inCdrData;
      if (rx_drop)   outOverflow    <= 1'b1;

      // idle timer is a down-counter; any transfer or cdr flag reloads it
      if (enter_frame) begin
        outBitCount <= '0;
        idle_left   <= IDLE_LOAD;
      end else if (outFifoReadEnable || rx_accept) begin
        outBitCount <= outBitCount + 8'd1;
        idle_left   <= IDLE_LOAD;
      end else if (rx_drop) begin
        idle_left <= IDLE_LOAD;
      end else if (((state == ST_TX) || (state == ST_RX)) && !idle_tc) begin
        idle_left <= idle_left - 16'd1;
      end

      if ((state_next == ST_TURN) && (state != ST_TURN)) turn_left <= TURN_LOAD;
      else if ((state == ST_TURN) && (turn_left != 8'd0)) turn_left <= turn_left - 8'd1;

      if (AUTO_RX && (state == ST_TX) && (state_next == ST_TURN)) auto_pending <= 1'b1;
      if ((state == ST_TURN) && (state_next == ST_RX)) begin
        auto_pending <= 1'b0;
        auto_rx      <= auto_pending;
      end else if ((state == ST_IDLE) && (state_next == ST_RX)) begin
        auto_rx <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_link_ctrl.sv
// Self-checking bench for link_ctrl: vector table, directed corner sequences and randomized frames
// checked against a frame-level model built from the transfer/idle counting rules.
module tb_link_ctrl;
  localparam int FRAME = 32;
  localparam int TMO   = 1024;
  localparam int TURN  = 8;
`ifdef LINK_AUTO_RX_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int AFTER_TX = AUTO ? 3 : 0;

  logic       inClock = 1'b0;
  logic       inReset, inTxRequest, inRxEnable, inFifoEmpty, inCoderReady;
  logic       inCdrFlag, inCdrData, inOutFifoFull;
  logic       outFifoReadEnable, outCoderEmpty, outOutFifoWriteEnable, outOutFifoData;
  logic       outBusy, outTxDone, outRxDone, outTimeout, outOverflow;
  logic [1:0] outState;
  logic [7:0] outBitCount;

  int tests  = 0;
  int failed = 0;
  bit ovf_exp;

  typedef struct {
    bit         tx, rx, empty, ready;
    logic [1:0] st;
    bit         rd, ce, busy;
  } vec_t;
  vec_t vecs[7];

  link_ctrl #(.FRAME_BITS(FRAME), .TIMEOUT_CYCLES(TMO), .TURNAROUND_CYCLES(TURN)) dut (
    .inClock(inClock), .inReset(inReset), .inTxRequest(inTxRequest), .inRxEnable(inRxEnable),
    .inFifoEmpty(inFifoEmpty), .inCoderReady(inCoderReady), .inCdrFlag(inCdrFlag),
    .inCdrData(inCdrData), .inOutFifoFull(inOutFifoFull),
    .outFifoReadEnable(outFifoReadEnable), .outCoderEmpty(outCoderEmpty),
    .outOutFifoWriteEnable(outOutFifoWriteEnable), .outOutFifoData(outOutFifoData),
    .outBusy(outBusy), .outTxDone(outTxDone), .outRxDone(outRxDone), .outTimeout(outTimeout),
    .outOverflow(outOverflow), .outState(outState), .outBitCount(outBitCount)
  );

  always #5 inClock = ~inClock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    failed++;
    $display("FAIL %s: cycle budget expired, got no end event, expected one (t=%0t)", name, $time);
  endtask

  task automatic cyc();
    @(posedge inClock);
    #1;
  endtask

  task automatic clear_inputs();
    inTxRequest = 0; inRxEnable = 0; inFifoEmpty = 0; inCoderReady = 0;
    inCdrFlag = 0; inCdrData = 0; inOutFifoFull = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    inReset = 0;
    cyc();
    inReset = 1;
    ovf_exp = 0;
  endtask

  task automatic enter(input bit tx, input bit rx);
    inTxRequest = tx;
    inRxEnable  = rx;
    cyc();
  endtask

  // mode 0: coder ready every 4th cycle; 1: FIFO runs dry after 10 bits; 2: random
  task automatic run_tx(input int mode, output int bits);
    int reads = 0, idle = 0;
    bit done_exp = 0, to_exp = 0, fin = 0, rdy, emp, rd;
    for (int n = 0; n < 3000; n++) begin
      check("tx_done", 32'(outTxDone), 32'(done_exp));
      check("tx_timeout", 32'(outTimeout), 32'(to_exp));
      check("tx_bits", 32'(outBitCount), reads);
      if (done_exp || to_exp) begin fin = 1; break; end
      check("tx_state", 32'(outState), 1);
      case (mode)
        0:       begin rdy = (n % 4 == 3); emp = 0; end
        1:       begin rdy = 1; emp = (reads >= 10); end
        default: begin
          rdy = 1'($urandom_range(0, 1));
          emp = ($urandom_range(0, 3) == 0);
          inTxRequest = 1'($urandom_range(0, 1));
        end
      endcase
      inCoderReady = rdy;
      inFifoEmpty  = emp;
      #1;
      rd = rdy & ~emp;
      check("tx_rd_en", 32'(outFifoReadEnable), 32'(rd));
      check("tx_coder_empty", 32'(outCoderEmpty), 32'(emp));
      if (rd) begin
        reads++; idle = 0;
        if (reads == FRAME) done_exp = 1;
      end else begin
        idle++;
        if (idle == TMO) to_exp = 1;
      end
      cyc();
    end
    if (!fin) fail_now("tx_budget");
    check("tx_end_state", 32'(outState), 2);
    bits = reads;
  endtask

  // mode 0: flag every 3rd cycle, alternating data; 1: flags 5,6 hit a full FIFO; 2: random; 3: silent
  task automatic run_rx(input int mode, input bit rx_level, output int bits);
    int cnt = 0, idle = 0, flags = 0;
    bit we_exp = 0, d_exp = 0, done_exp = 0, to_exp = 0, fin = 0, flg, dat, full;
    inRxEnable = rx_level;
    for (int n = 0; n < 3000; n++) begin
      check("rx_we", 32'(outOutFifoWriteEnable), 32'(we_exp));
      if (we_exp) check("rx_data", 32'(outOutFifoData), 32'(d_exp));
      check("rx_done", 32'(outRxDone), 32'(done_exp));
      check("rx_timeout", 32'(outTimeout), 32'(to_exp));
      check("rx_bits", 32'(outBitCount), cnt);
      check("rx_overflow", 32'(outOverflow), 32'(ovf_exp));
      if (done_exp || to_exp) begin fin = 1; break; end
      check("rx_state", 32'(outState), 3);
      case (mode)
        0:       begin flg = (n % 3 == 1); dat = flags[0]; full = 0; end
        1:       begin flg = (n % 2 == 0); dat = 1'($urandom_range(0, 1)); full = flg && (flags == 4 || flags == 5); end
        2:       begin flg = 1'($urandom_range(0, 1)); dat = 1'($urandom_range(0, 1)); full = ($urandom_range(0, 7) == 0); end
        default: begin flg = 0; dat = 0; full = 1'($urandom_range(0, 1)); end
      endcase
      inCdrFlag = flg; inCdrData = dat; inOutFifoFull = full;
      inCoderReady = 1'($urandom_range(0, 1));
      #1;
      check("rx_rd_en", 32'(outFifoReadEnable), 0);
      we_exp = 0;
      if (flg) begin
        flags++; idle = 0;
        if (full) ovf_exp = 1;
        else begin
          cnt++; we_exp = 1; d_exp = dat;
          if (cnt == FRAME) done_exp = 1;
        end
      end else begin
        idle++;
        if (idle == TMO) to_exp = 1;
      end
      cyc();
    end
    if (!fin) fail_now("rx_budget");
    check("rx_end_state", 32'(outState), 2);
    bits = cnt;
  endtask

  // starts on the first TURN cycle; flags and requests thrown at it must be ignored
  task automatic check_turn(input int bits, input int nxt);
    clear_inputs();
    for (int i = 0; i < TURN; i++) begin
      check("turn_state", 32'(outState), 2);
      check("turn_bits", 32'(outBitCount), bits);
      check("turn_overflow", 32'(outOverflow), 32'(ovf_exp));
      if (i > 0) check("turn_quiet", 32'({outTxDone, outRxDone, outTimeout, outOutFifoWriteEnable}), 0);
      inCdrFlag = 1'($urandom_range(0, 1)); inCdrData = 1;
      inTxRequest = 1'($urandom_range(0, 1)); inRxEnable = 1'($urandom_range(0, 1));
      #1;
      check("turn_busy", 32'(outBusy), 1);
      check("turn_coder_empty", 32'(outCoderEmpty), 1);
      cyc();
    end
    check("turn_exit", 32'(outState), nxt);
    check("turn_flag_dropped", 32'(outOutFifoWriteEnable), 0);
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected summary first");
    $fatal(1, "watchdog");
  end

  initial begin
    int bits;
    bit fin;
    //         tx rx emp rdy  state  rd ce busy
    vecs[0] = '{0, 0, 0, 1, 2'd0, 0, 1, 0};
    vecs[1] = '{1, 0, 0, 1, 2'd1, 1, 0, 1};
    vecs[2] = '{0, 1, 0, 1, 2'd3, 0, 1, 1};
    vecs[3] = '{1, 1, 0, 1, 2'd1, 1, 0, 1};
    vecs[4] = '{1, 0, 1, 1, 2'd1, 0, 1, 1};
    vecs[5] = '{1, 0, 0, 0, 2'd1, 0, 0, 1};
    vecs[6] = '{1, 1, 1, 0, 2'd1, 0, 1, 1};

    clear_inputs();
    inReset = 0;
    ovf_exp = 0;
    cyc(); cyc();
    check("rst_state", 32'(outState), 0);
    check("rst_bits", 32'(outBitCount), 0);
    check("rst_pulses", 32'({outTxDone, outRxDone, outTimeout}), 0);
    check("rst_write", 32'({outOutFifoWriteEnable, outOutFifoData}), 0);
    check("rst_overflow", 32'(outOverflow), 0);
    check("rst_busy", 32'(outBusy), 0);
    check("rst_coder_empty", 32'(outCoderEmpty), 1);
    inReset = 1;

    foreach (vecs[k]) begin
      do_reset();
      enter(vecs[k].tx, vecs[k].rx);
      inFifoEmpty  = vecs[k].empty;
      inCoderReady = vecs[k].ready;
      #1;
      check("vec_state", 32'(outState), 32'(vecs[k].st));
      check("vec_rd_en", 32'(outFifoReadEnable), 32'(vecs[k].rd));
      check("vec_coder_empty", 32'(outCoderEmpty), 32'(vecs[k].ce));
      check("vec_busy", 32'(outBusy), 32'(vecs[k].busy));
    end

    // full TX frame, coder pacing every 4th cycle
    do_reset();
    enter(1, 0);
    run_tx(0, bits);
    check_turn(bits, AFTER_TX);
    if (AUTO) begin
      run_rx(0, 0, bits);
      check_turn(bits, 0);
    end

    // RX frame with alternating data
    do_reset();
    enter(0, 1);
    run_rx(0, 1, bits);
    check_turn(bits, 0);

    // RX with two drops on a full outFIFO; overflow stays sticky into the next frame
    do_reset();
    enter(0, 1);
    run_rx(1, 1, bits);
    check_turn(bits, 0);
    enter(0, 1);
    run_rx(2, 1, bits);
    check_turn(bits, 0);

    // TX starves after 10 bits and times out
    do_reset();
    enter(1, 0);
    run_tx(1, bits);
    check_turn(bits, AFTER_TX);

    // RX silent until timeout
    do_reset();
    enter(0, 1);
    run_rx(3, 1, bits);
    check_turn(bits, 0);

    // reset in the middle of a TX frame
    do_reset();
    enter(1, 1);
    check("both_req_tx", 32'(outState), 1);
    inCoderReady = 1;
    fin = 0;
    for (int n = 0; n < 100; n++) begin
      if (outBitCount == 8'd17) begin fin = 1; break; end
      cyc();
    end
    if (!fin) fail_now("mid_reset_budget");
    inReset = 0;
    cyc();
    check("mid_reset_state", 32'(outState), 0);
    check("mid_reset_bits", 32'(outBitCount), 0);
    check("mid_reset_pulses", 32'({outTxDone, outRxDone, outTimeout, outOutFifoWriteEnable}), 0);
    clear_inputs();
    inReset = 1;
    cyc();
    check("mid_reset_no_done", 32'({outTxDone, outState}), 0);

    // RX aborted by inRxEnable drop; the registered write still lands
    do_reset();
    enter(0, 1);
    for (int i = 0; i < 4; i++) begin
      inCdrFlag = 1;
      inCdrData = 1'(i % 2);
      cyc();
    end
    inCdrFlag  = 0;
    inRxEnable = 0;
    #1;
    check("abort_we", 32'(outOutFifoWriteEnable), 1);
    check("abort_data", 32'(outOutFifoData), 1);
    check("abort_state_rx", 32'(outState), 3);
    cyc();
    check("abort_state_turn", 32'(outState), 2);
    check("abort_no_pulse", 32'({outRxDone, outTimeout, outOutFifoWriteEnable}), 0);
    check_turn(4, 0);

    // randomized frames
    for (int r = 0; r < 6; r++) begin
      do_reset();
      if ($urandom_range(0, 1) == 1) begin
        enter(1, 1'($urandom_range(0, 1)));
        run_tx(2, bits);
        check_turn(bits, AFTER_TX);
        if (AUTO) begin
          run_rx(2, 1'($urandom_range(0, 1)), bits);
          check_turn(bits, 0);
        end
      end else begin
        enter(0, 1);
        run_rx(2, 1, bits);
        check_turn(bits, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/link_ctrl.md
Name: link_ctrl

Overview:
Half-duplex link controller for the Zigbee MSK chain.
- TX side: sequences inFIFO → msk_modulator by gating the FIFO read enable and the coder empty flag.
- RX side: sequences cdr → outFIFO by registering recovered bits into the FIFO write port.
- Arbitrates between TX requests and RX listening, counts frame bits, and enforces a guard turnaround and an inactivity timeout.
- Sits between the datapath blocks, in place of the test-mux glue, in mission mode.

Parameters:
- FRAME_BITS, 32: bits per frame, TX and RX (range 1..255).
- TIMEOUT_CYCLES, 1024: inactivity cycles before abort (range 2..65535).
- TURNAROUND_CYCLES, 8: guard cycles between frames (range 1..255).

Ports:
- inClock, in, 1: clock.
- inReset, in, 1: reset; synchronous, active-low.
- inTxRequest, in, 1: level request to transmit one frame.
- inRxEnable, in, 1: level enable for receive listening.
- inFifoEmpty, in, 1: inFIFO outEmpty.
- inCoderReady, in, 1: coder o_ready (requests next bit).
- inCdrFlag, in, 1: cdr o_flag (bit valid, 1-cycle pulse).
- inCdrData, in, 1: cdr o_data.
- inOutFifoFull, in, 1: outFIFO outFull.
- outFifoReadEnable, out, 1: inFIFO inReadEnable.
- outCoderEmpty, out, 1: coder i_empty.
- outOutFifoWriteEnable, out, 1: outFIFO inWriteEnable.
- outOutFifoData, out, 1: outFIFO inData.
- outBusy, out, 1: state != IDLE.
- outTxDone, out, 1: 1-cycle pulse, TX frame complete.
- outRxDone, out, 1: 1-cycle pulse, RX frame complete.
- outTimeout, out, 1: 1-cycle pulse, TX or RX aborted by timeout.
- outOverflow, out, 1: sticky, RX bit dropped on full outFIFO.
- outState, out, 2: IDLE=0, TX=1, TURN=2, RX=3.
- outBitCount, out, 8: bits transferred in the current frame.

Behaviour:
- Reset (inReset=0 at a clock edge):
  - State goes to IDLE.
  - All counters are 0.
  - outOverflow=0, all pulses=0, outOutFifoWriteEnable=0, outOutFifoData=0.
  - Reset takes priority over every event, including mid-frame. Partially transferred bits are abandoned and no done pulse is issued.
- Combinational outputs:
  - outFifoReadEnable = (state==TX) & inCoderReady & ~inFifoEmpty.
  - outCoderEmpty = (state!=TX) | inFifoEmpty.
  - outBusy = (state!=IDLE).
- IDLE:
  - inTxRequest=1 → TX. TX wins when inTxRequest and inRxEnable are both high.
  - Else inRxEnable=1 → RX.
  - On entry to TX or RX, the bit counter and idle counter clear.
- TX:
  - Each cycle with outFifoReadEnable=1 increments outBitCount and clears the idle counter.
  - Any other cycle increments the idle counter. An empty inFIFO stalls the frame; the coder sees i_empty=1.
  - The read that makes outBitCount==FRAME_BITS asserts outTxDone on the next cycle and moves to TURN.
  - Idle counter reaching TIMEOUT_CYCLES-1 asserts outTimeout for 1 cycle and moves to TURN.
  - inTxRequest deassertion mid-frame is ignored; the frame completes.
- RX:
  - If inCdrFlag=1 and inOutFifoFull=0: the next cycle drives outOutFifoWriteEnable=1 with outOutFifoData=inCdrData as sampled (1-cycle latency). outBitCount increments and the idle counter clears.
  - If inCdrFlag=1 and inOutFifoFull=1: the bit is dropped, not counted, and outOverflow sets. outOverflow clears only by reset.
  - Write of bit FRAME_BITS asserts outRxDone in the same cycle as that write, then moves to TURN.
  - Timeout behaves as in TX, with the idle counter cleared by each flag.
  - inRxEnable=0 mid-frame → TURN with no done pulse and no timeout pulse. A write already registered still completes.
- TURN:
  - Counts TURNAROUND_CYCLES, then goes to IDLE.
  - All inputs are ignored; cdr flags arriving in TURN are discarded.
- Simultaneous events:
  - Done and timeout in the same cycle: done wins and no timeout pulse is issued.
  - outBitCount holds its value through TURN and clears on the next TX or RX entry.

Optional Feature:
LINK_AUTO_RX_EN
- Defined: after a TX frame ends (done or timeout), TURN exits directly to RX regardless of inRxEnable, to listen for an acknowledgement. This RX frame ends by done or timeout only; inRxEnable=0 does not abort it. TX does not follow an auto-RX frame without passing through IDLE.
- Undefined: TURN always exits to IDLE.

Test Plan:
1. Reset, inFIFO holding 32 bits, coder ready every 4th cycle, inTxRequest=1 → exactly 32 outFifoReadEnable pulses, then outTxDone pulse, outState=2 for 8 cycles, then 0.
2. inRxEnable=1, 32 inCdrFlag pulses with alternating data → 32 writes, each one cycle after its flag with matching data; outRxDone on the 32nd write; outBitCount=32.
3. RX with inOutFifoFull=1 on flags 5 and 6 → 30 writes, outOverflow=1 and stays high, no outRxDone until 2 more flags arrive.
4. TX with inFIFO empty after 10 bits → outCoderEmpty=1; after 1024 idle cycles outTimeout pulse, TURN, IDLE; no outTxDone.
5. inTxRequest and inRxEnable both rise together in IDLE → TX entered. inReset=0 asserted at bit 17 → next cycle outState=0, outBitCount=0, no pulses.
6. With LINK_AUTO_RX_EN defined, inRxEnable=0: a TX frame completes → after 8 TURN cycles outState=3. Without the macro → outState=0.
